dm_obi_initiator: RTL

// - OBI initiator (manager) that issues bus accesses on behalf of an upstream command source.
// - Upstream source: a system-bus-access engine with a simple valid/ready command/response interface.
// - Drives any OBI-compliant responder, e.g. a debug module exposed through an OBI wrapper.
// - Hides OBI gnt/rvalid/aid/rid handling, supports multiple in-order outstanding transactions, never drops a response.

---
 rtl/dm_obi_initiator.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dm_obi_initiator.sv
// OBI initiator: turns a valid/ready command/response stream into OBI address and
// response phases, with in-order outstanding transactions and a response FIFO.
module dm_obi_initiator #(
    parameter int unsigned BusWidth       = 32,
    parameter int unsigned IdWidth        = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // upstream command
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [BusWidth-1:0]   cmd_addr_i,
    input  logic [BusWidth/8-1:0] cmd_be_i,
    input  logic [BusWidth-1:0]   cmd_wdata_i,
    // upstream response
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BusWidth-1:0]   rsp_rdata_o,
    output logic                  rsp_err_o,
    // OBI address phase
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic                  obi_we_o,
    output logic [BusWidth-1:0]   obi_addr_o,
    output logic [BusWidth/8-1:0] obi_be_o,
    output logic [BusWidth-1:0]   obi_wdata_o,
    output logic [IdWidth-1:0]    obi_aid_o,
    // OBI response phase
    input  logic                  obi_rvalid_i,
    input  logic [BusWidth-1:0]   obi_rdata_i,
    input  logic                  obi_err_i,
    input  logic [IdWidth-1:0]    obi_rid_i,
    output logic                  proto_err_o
);

    localparam int unsigned BeWidth  = BusWidth / 8;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] inflight_q;
    logic [CntWidth-1:0] fifo_cnt_q;
    logic [IdWidth-1:0]  aid_q;
    logic [IdWidth-1:0]  rid_exp_q;
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [BusWidth-1:0] fifo_rdata_q [MaxOutstanding];
    logic                fifo_err_q   [MaxOutstanding];
    logic                proto_err_q;

    logic cmd_accept;
    logic rsp_pop;
    logic obi_fire;
    logic rvalid_ok;
    logic rvalid_spurious;
    logic rid_mismatch;

    // Pointer increment that wraps at the FIFO depth, which need not be a power of two.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(MaxOutstanding - 1)) ? '0 : ptr + PtrWidth'(1);
    endfunction

    // The address-phase slot frees up in the same cycle it is granted.
    assign cmd_ready_o     = (!obi_req_o || obi_gnt_i) && (cnt_q < CntWidth'(MaxOutstanding));
    assign cmd_accept      = cmd_valid_i && cmd_ready_o;
    assign rsp_pop         = rsp_valid_o && rsp_ready_i;
    assign obi_fire        = obi_req_o && obi_gnt_i;
    assign rvalid_ok       = obi_rvalid_i && (inflight_q != '0);
    assign rvalid_spurious = obi_rvalid_i && (inflight_q == '0);
    assign rid_mismatch    = rvalid_ok && (obi_rid_i != rid_exp_q);

    assign rsp_valid_o = (fifo_cnt_q != '0);
    assign rsp_rdata_o = fifo_rdata_q[rd_ptr_q];
    assign rsp_err_o   = fifo_err_q[rd_ptr_q];
    assign proto_err_o = proto_err_q;

    // Address-phase register: payload is only reloaded on accept, so it holds while ungranted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            obi_req_o   <= 1'b0;
            obi_we_o    <= 1'b0;
            obi_addr_o  <= '0;
            obi_be_o    <= '0;
            obi_wdata_o <= '0;
            obi_aid_o   <= '0;
            aid_q       <= '0;
        end else if (cmd_accept) begin
            obi_req_o   <= 1'b1;
            obi_we_o    <= cmd_we_i;
            obi_addr_o  <= cmd_addr_i;
            obi_be_o    <= BeWidth'(cmd_be_i);
            obi_wdata_o <= cmd_wdata_i;
            obi_aid_o   <= aid_q;
            aid_q       <= aid_q + IdWidth'(1);
        end else if (obi_fire) begin
            obi_req_o   <= 1'b0;
        end
    end

    // Credit, in-flight and expected-ID tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            inflight_q  <= '0;
            rid_exp_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            case ({cmd_accept, rsp_pop})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
            case ({obi_fire, rvalid_ok})
                2'b10:   inflight_q <= inflight_q + CntWidth'(1);
                2'b01:   inflight_q <= inflight_q - CntWidth'(1);
                default: inflight_q <= inflight_q;
            endcase
            if (rvalid_ok) begin
                rid_exp_q <= rid_exp_q + IdWidth'(1);
            end
            if (rvalid_spurious || rid_mismatch) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // Response FIFO; cnt_q bounds outstanding work so a push never meets a full FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                fifo_rdata_q[i] <= '0;
                fifo_err_q[i]   <= 1'b0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (rvalid_ok) begin
                fifo_rdata_q[wr_ptr_q] <= obi_rdata_i;
                fifo_err_q[wr_ptr_q]   <= obi_err_i || rid_mismatch;
                wr_ptr_q               <= ptr_inc(wr_ptr_q);
            end
            if (rsp_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({rvalid_ok, rsp_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CntWidth'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CntWidth'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule
